// File: rtl/branch_cmp_pipe_if.sv
// Operand/result handshake bundle for branch_cmp_pipe.
// master drives operands and accepts results; slave is the comparator.
interface branch_cmp_pipe_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic             out_taken;
    logic [6:0]       out_flags;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_taken, out_flags
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_taken, out_flags
    );
endinterface

// File: rtl/branch_cmp_pipe.sv
// Pipelined branch/set comparator: evaluates the condition and flag vector on accept,
// then carries them through STAGES elastic register stages with flush and a taken counter.
module branch_cmp_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    branch_cmp_pipe_if.slave  bus,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  taken_cnt
);

    typedef enum logic [3:0] {
        OP_BEQ  = 4'd0,
        OP_BNE  = 4'd1,
        OP_BLEZ = 4'd2,
        OP_BGTZ = 4'd3,
        OP_BLTZ = 4'd4,
        OP_BGEZ = 4'd5,
        OP_SLT  = 4'd6,
        OP_SLTU = 4'd7
    } op_e;

    logic       eq, a_ltz, a_eqz, a_gtz, lts, ltu, bad_op;
    logic       taken_c;
    logic [6:0] flags_c;

    always_comb begin
        eq      = (bus.in_a == bus.in_b);
        a_ltz   = bus.in_a[WIDTH-1];
        a_eqz   = (bus.in_a == '0);
        a_gtz   = !a_ltz && !a_eqz;
        lts     = ($signed(bus.in_a) < $signed(bus.in_b));
        ltu     = (bus.in_a < bus.in_b);
        bad_op  = (bus.in_op > 4'd7);
        flags_c = {bad_op, ltu, lts, a_gtz, a_eqz, a_ltz, eq};
        taken_c = 1'b0;
        case (bus.in_op)
            OP_BEQ:  taken_c = eq;
            OP_BNE:  taken_c = !eq;
            OP_BLEZ: taken_c = a_ltz || a_eqz;
            OP_BGTZ: taken_c = a_gtz;
            OP_BLTZ: taken_c = a_ltz;
            OP_BGEZ: taken_c = !a_ltz;
            OP_SLT:  taken_c = lts;
            OP_SLTU: taken_c = ltu;
            default: taken_c = 1'b0;
        endcase
    end

    // Per stage: {taken, flags}
    logic [STAGES-1:0]      vld;
    logic [STAGES-1:0]      ld;
    logic [STAGES-1:0][7:0] data;
    logic                   accept;

    // A stage may load when it is empty or its occupant leaves this cycle;
    // the chain is walked from the output back towards stage 0.
    always_comb begin
        logic chain;
        ld    = '0;
        chain = !vld[STAGES-1] || bus.out_ready;
        ld[STAGES-1] = chain;
        for (int unsigned k = 1; k < STAGES; k++) begin
            chain = !vld[STAGES-1-k] || chain;
            ld[STAGES-1-k] = chain;
        end
    end

    assign accept        = bus.in_valid && ld[0];
    assign bus.in_ready  = ld[0];
    assign bus.out_valid = vld[STAGES-1];
    assign bus.out_taken = data[STAGES-1][7];
    assign bus.out_flags = data[STAGES-1][6:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld       <= '0;
            data      <= '0;
            taken_cnt <= '0;
        end else begin
            if (flush) begin
                vld <= '0;
            end else begin
                if (ld[0]) vld[0] <= bus.in_valid;
                for (int unsigned i = 1; i < STAGES; i++) begin
                    if (ld[i]) vld[i] <= vld[i-1];
                end
            end

            // Data only moves with a valid entry, so a stalled output holds steady.
            if (accept) data[0] <= {taken_c, flags_c};
            for (int unsigned i = 1; i < STAGES; i++) begin
                if (ld[i] && vld[i-1]) data[i] <= data[i-1];
            end

            if (cnt_clr) begin
                taken_cnt <= '0;
            end else if (bus.out_valid && bus.out_ready && bus.out_taken && (taken_cnt != '1)) begin
                taken_cnt <= taken_cnt + CNT_W'(1);
            end
        end
    end

endmodule
